mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Initiator side of the single-port synchronous RAM interface.
- Arbitrates between an instruction-fetch requester (read-only) and a data load/store requester, then drives the RAM's address, write-enable and write-data inputs.
- Returns read data using the RAM's fixed one-cycle registered read latency.
- Sits between the CPU core's fetch/execute stages and the memory instance.

Parameters:
ADDR_WIDTH, 12, width of all address signals
DATA_WIDTH, 12, width of all data signals
STARVE_LIMIT, 4, consecutive conflict cycles data may win before fetch is forced through; 0 = fetch always wins conflicts

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_req_valid  input  1  fetch read request
if_req_addr  input  ADDR_WIDTH  fetch address
if_req_ready  output  1  fetch request accepted this cycle
if_rsp_valid  output  1  fetch read data valid
if_rsp_data  output  DATA_WIDTH  fetch read data
d_req_valid  input  1  data request
d_req_we  input  1  1 = write, 0 = read
d_req_addr  input  ADDR_WIDTH  data address
d_req_wdata  input  DATA_WIDTH  write data
d_req_ready  output  1  data request accepted this cycle
d_rsp_valid  output  1  data read data valid (reads only)
d_rsp_data  output  DATA_WIDTH  data read data
mem_addr  output  ADDR_WIDTH  to RAM addr
mem_write_enable  output  1  to RAM write_enable
mem_data_in  output  DATA_WIDTH  to RAM data_in
mem_data_out  input  DATA_WIDTH  from RAM data_out (registered, updated only on non-write edges)

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- While rst_n=0:
  - if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_write_enable = 0.
  - mem_addr, mem_data_in = 0.
  - starve_cnt = 0.
- Grant selection (combinational, each cycle):
  - Only one requester valid: grant it.
  - Both valid: grant data if starve_cnt < STARVE_LIMIT, otherwise grant fetch.
  - Neither valid: no grant.
- Ready: *_req_ready = 1 exactly for the granted requester. A request is accepted on the rising edge where valid && ready. Requesters hold valid, addr and data stable until accepted.
- RAM drive (combinational from the grant):
  - Fetch granted: mem_addr = if_req_addr, mem_write_enable = 0.
  - Data granted: mem_addr = d_req_addr, mem_write_enable = d_req_we, mem_data_in = d_req_wdata.
  - No grant: mem_addr = 0, mem_write_enable = 0, mem_data_in = 0.
- Latency:
  - Accepted read: the matching *_rsp_valid is registered high for exactly the one following cycle.
  - *_rsp_data = mem_data_out passthrough, meaningful only while *_rsp_valid = 1.
  - Accepted write: completes on the accept edge. No response is generated.
- Pipelining:
  - One acceptance per cycle, no bubbles. Back-to-back reads return one response per cycle, in order.
  - A write accepted in a response cycle does not corrupt that response, because the RAM holds data_out on write edges.
- No response backpressure: requesters must consume *_rsp_valid in its cycle.
- starve_cnt (width clog2(STARVE_LIMIT+1), saturating at STARVE_LIMIT):
  - +1 on edges where both requesters are valid and data is granted.
  - Cleared on any edge where fetch is granted or if_req_valid = 0.
- Read-after-write: a write accepted on cycle N followed by any read of the same address accepted on N+1 returns the new data.
- Reset mid-operation: pending rsp_valid clears immediately (asynchronously). The in-flight read response is lost, and no response appears after rst_n releases.
- Address wrap: none. Addresses pass through unmodified.

Test Plan:
1. Preload RAM[0x010]=0xABC; pulse if_req_valid with addr 0x010 -> if_req_ready=1 in the same cycle, mem_addr=0x010; next cycle if_rsp_valid=1, if_rsp_data=0xABC; the cycle after that, if_rsp_valid=0.
2. Data write 0x020<=0x5A5 followed immediately by data read 0x020 -> mem_write_enable=1 for one cycle, no d_rsp_valid for the write; d_rsp_valid=1 with 0x5A5 the cycle after the read accept.
3. STARVE_LIMIT=4, both requesters valid for 12 cycles (data reads) -> grant sequence D,D,D,D,F,D,D,D,D,F,D,D; every response lands on the correct port.
4. Fetch reads 0x000..0x003 on four consecutive cycles, RAM holding 0x111..0x444 -> if_rsp_valid high four consecutive cycles, data 0x111,0x222,0x333,0x444 in order.
5. Fetch read accepted, then rst_n pulled low mid next cycle -> if_rsp_valid drops asynchronously; all outputs stay at reset values; after release, no stale response and starve_cnt=0.
6. Data write 0x030<=0x777, fetch read 0x030 on the next cycle, plus a data write to 0x031 in the fetch response cycle -> if_rsp_data=0x777 with if_rsp_valid=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates an instruction-fetch and a data requester onto a
// single-port synchronous RAM, returning read data one cycle after acceptance.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  // A limit of 0 still needs a 1-bit counter; it simply never increments.
  localparam int               CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_if_rsp_valid;
  logic             r_d_rsp_valid;
  logic             w_conflict;
  logic             w_grant_d;
  logic             w_grant_f;

  assign w_conflict = if_req_valid && d_req_valid;

  // Grants are gated by rst_n so the RAM port and readies sit idle during reset.
  assign w_grant_d = rst_n && d_req_valid && (!if_req_valid || (r_starve_cnt < LIMIT));
  assign w_grant_f = rst_n && if_req_valid && !w_grant_d;

  assign if_req_ready = w_grant_f;
  assign d_req_ready  = w_grant_d;

  always_comb begin
    mem_addr         = '0;
    mem_write_enable = 1'b0;
    mem_data_in      = '0;
    if (w_grant_d) begin
      mem_addr         = d_req_addr;
      mem_write_enable = d_req_we;
      mem_data_in      = d_req_wdata;
    end else if (w_grant_f) begin
      mem_addr = if_req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      r_starve_cnt   <= '0;
    end else begin
      r_if_rsp_valid <= w_grant_f;
      r_d_rsp_valid  <= w_grant_d && !d_req_we;
      if (w_conflict && w_grant_d) begin
        if (r_starve_cnt != LIMIT)
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  assign if_rsp_valid = r_if_rsp_valid;
  assign d_rsp_valid  = r_d_rsp_valid;
  assign if_rsp_data  = mem_data_out;
  assign d_rsp_data   = mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural memory/arbitration model.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_valid, d_req_valid, d_req_we;
  logic [AW-1:0] if_req_addr, d_req_addr, mem_addr;
  logic [DW-1:0] d_req_wdata, if_rsp_data, d_rsp_data, mem_data_in, mem_data_out;
  logic          if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, mem_write_enable;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM: data_out only updates on non-write edges.
  logic [DW-1:0] ram [0:63];
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_addr[5:0]] <= mem_data_in;
    else                  mem_data_out <= ram[mem_addr[5:0]];
  end

  int            n_cmp = 0;
  int            n_err = 0;
  int            starve = 0;
  logic [DW-1:0] mdl [0:63];
  logic          pend_if_v = 1'b0, pend_d_v = 1'b0;
  logic [DW-1:0] pend_if_d = '0, pend_d_d = '0;
  logic          last_gf, last_gd, obs_gd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs and due responses, advance model.
  task automatic cycle(input logic fv, input logic [AW-1:0] fa, input logic dv,
                       input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    logic gd, gf;
    @(negedge clk);
    if_req_valid = fv; if_req_addr = fa;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
    #1;
    gd = dv && (!fv || starve < SL);
    gf = fv && !gd;
    obs_gd = d_req_ready;
    check("if_ready", if_req_ready, gf);
    check("d_ready", d_req_ready, gd);
    check("mem_addr", mem_addr, gd ? da : (gf ? fa : '0));
    check("mem_we", mem_write_enable, gd && dwe);
    if (!gf) check("mem_din", mem_data_in, gd ? dwd : '0);
    check("if_rsp_valid", if_rsp_valid, pend_if_v);
    check("d_rsp_valid", d_rsp_valid, pend_d_v);
    if (pend_if_v) check("if_rsp_data", if_rsp_data, pend_if_d);
    if (pend_d_v)  check("d_rsp_data", d_rsp_data, pend_d_d);
    pend_if_v = gf;
    pend_if_d = mdl[fa[5:0]];
    pend_d_v  = gd && !dwe;
    pend_d_d  = mdl[da[5:0]];
    if (gd && dwe) mdl[da[5:0]] = dwd;
    starve = (fv && dv && gd) ? ((starve < SL) ? starve + 1 : SL) : 0;
    last_gf = gf;
    last_gd = gd;
    @(posedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Called right after an accept edge; asserts reset in the middle of the response cycle.
  task automatic reset_mid();
    #1;
    check("pre_rst_if_v", if_rsp_valid, pend_if_v);
    check("pre_rst_d_v", d_rsp_valid, pend_d_v);
    #2 rst_n = 1'b0;
    #1;
    check("rst_if_v", if_rsp_valid, 1'b0);
    check("rst_d_v", d_rsp_valid, 1'b0);
    check("rst_if_ready", if_req_ready, 1'b0);
    check("rst_d_ready", d_req_ready, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_we", mem_write_enable, 1'b0);
    check("rst_mem_din", mem_data_in, '0);
    pend_if_v = 1'b0; pend_d_v = 1'b0; starve = 0;
    @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_if_v", if_rsp_valid, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic          fp, dp, dwe;
    logic [AW-1:0] fa, da;
    logic [DW-1:0] dwd;
    logic [11:0]   seq;
    if_req_valid = 1'b1; if_req_addr = 12'h005;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 12'h006; d_req_wdata = 12'h7AA;
    #2;
    check("init_if_ready", if_req_ready, 1'b0);
    check("init_d_ready", d_req_ready, 1'b0);
    check("init_if_v", if_rsp_valid, 1'b0);
    check("init_d_v", d_rsp_valid, 1'b0);
    check("init_mem_we", mem_write_enable, 1'b0);
    check("init_mem_addr", mem_addr, '0);
    check("init_mem_din", mem_data_in, '0);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill the RAM through the arbiter so bench model and RAM agree.
    for (int i = 0; i < 64; i++) begin
      dwd = (i < 4) ? 12'(12'h111 * (i + 1)) : (i == 16) ? 12'hABC : 12'(i * 37 + 5);
      cycle(1'b0, '0, 1'b1, 1'b1, 12'(i), dwd);
    end
    idle();

    // Single fetch read.
    cycle(1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    #1 check("t1_if_data", if_rsp_data, 12'hABC);
    idle();
    idle();

    // Write then read of the same address.
    cycle(1'b0, '0, 1'b1, 1'b1, 12'h020, 12'h5A5);
    cycle(1'b0, '0, 1'b1, 1'b0, 12'h020, '0);
    #1 check("t2_d_data", d_rsp_data, 12'h5A5);
    idle();

    // Sustained conflict: data wins up to the starve limit, then fetch.
    seq = 12'b1101_1110_1111;
    fa = 12'h008;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, fa, 1'b1, 1'b0, 12'(20 + i), '0);
      check("t3_grant_seq", obs_gd, seq[i]);
      if (last_gf) fa = fa + 12'h001;
    end
    idle();
    idle();

    // Back-to-back fetch reads.
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'(i), 1'b0, 1'b0, '0, '0);
    idle();
    idle();

    // Reset during a fetch response, then during a data response with starve_cnt at its limit.
    cycle(1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    reset_mid();
    idle();
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'h002, 1'b1, 1'b0, 12'(40 + i), '0);
    reset_mid();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 12'h002, 1'b1, 1'b0, 12'(44 + i), '0);
      check("t5_post_rst_seq", obs_gd, (i < 4) ? 1'b1 : 1'b0);
    end
    idle();
    idle();

    // Fetch read-after-write with a write landing in the response cycle.
    cycle(1'b0, '0, 1'b1, 1'b1, 12'h030, 12'h777);
    cycle(1'b1, 12'h030, 1'b0, 1'b0, '0, '0);
    #1 check("t6_if_data", if_rsp_data, 12'h777);
    cycle(1'b0, '0, 1'b1, 1'b1, 12'h031, 12'h123);
    idle();

    // Randomized traffic; requesters hold their request until accepted.
    fp = 1'b0; dp = 1'b0; fa = '0; da = '0; dwe = 1'b0; dwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!fp) begin
        fp = ($urandom_range(0, 99) < 65);
        fa = 12'($urandom_range(0, 63));
      end
      if (!dp) begin
        dp  = ($urandom_range(0, 99) < 70);
        dwe = 1'($urandom_range(0, 1));
        da  = 12'($urandom_range(0, 63));
        dwd = 12'($urandom);
      end
      cycle(fp, fa, dp, dwe, da, dwd);
      if (last_gf) fp = 1'b0;
      if (last_gd) dp = 1'b0;
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
